// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 receiver.
// Build option: define PS2_CODE_MERGE_EN to fold E0/F0 prefixes into 10-bit FIFO entries.
package ps2_pkg;

`ifdef PS2_CODE_MERGE_EN
    localparam int ENTRY_W   = 10;
    localparam int VALID_BIT = 16;
`else
    localparam int ENTRY_W   = 8;
    localparam int VALID_BIT = 8;
`endif

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;

    localparam int ST_NEMPTY = 0;
    localparam int ST_FULL   = 1;
    localparam int ST_OVF    = 2;
    localparam int ST_PERR   = 3;
    localparam int ST_FERR   = 4;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_IRQ_EN = 1;

    localparam logic [7:0] CODE_EXT = 8'hE0;
    localparam logic [7:0] CODE_BRK = 8'hF0;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

endpackage

// File: rtl/ps2_input_filter.sv
// Two-flop synchroniser followed by a stability filter for one raw PS/2 pin.
// The filtered level only follows the pin after DEB_CYCLES equal synchronised samples.
module ps2_input_filter #(
    parameter int DEB_CYCLES = 20
) (
    input  logic clk,
    input  logic wb_rst_ni,
    input  logic raw_i,
    output logic filt_o
);

    localparam int CNT_W = $clog2(DEB_CYCLES + 1);

    logic             sync1_q, sync2_q;
    logic             filt_q, filt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // NOTE: every output of an always_comb gets a default first, otherwise a latch is inferred.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (sync2_q != filt_q) begin
            if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
                filt_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            filt_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign filt_o = filt_q;

endmodule

// File: rtl/ps2_rx_fifo_wb.sv
// PS/2 keyboard receiver: filtered frame decoder, scan-code FIFO and Wishbone registers.
// Build option: PS2_CODE_MERGE_EN merges E0/F0 prefixes into the following scan code.
module ps2_rx_fifo_wb
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 16,
    parameter int DEB_CYCLES     = 20,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        wb_rst_ni,
    input  logic        ps2_clk_i,
    input  logic        ps2_data_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        irq_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic ps2_clk_f, ps2_data_f;
    logic ps2_clk_prev_q;
    logic fall;

    rx_state_e     state_q, state_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic          par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          frame_ok, perr_set, ferr_set;

    logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               push_req;
    logic [ENTRY_W-1:0] push_data;
    logic               do_push, do_pop, fifo_full, fifo_nempty, ovf_set;

    logic        ovf_q, ovf_d, perr_q, perr_d, ferr_q, ferr_d;
    logic        en_q, en_d, irq_en_q, irq_en_d;
    logic        wb_ack_q, wb_ack_d, irq_q, irq_d;
    logic [31:0] wb_dat_q, wb_dat_d, rdata;
    logic        wb_req, wb_rd, wb_wr, status_wr;
    logic [1:0]  reg_sel;

    logic unused_bits;
    assign unused_bits = ^{wb_sel_i, wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[31:5]};

    ps2_input_filter #(.DEB_CYCLES(DEB_CYCLES)) u_clk_filt (
        .clk       (clk),
        .wb_rst_ni (wb_rst_ni),
        .raw_i     (ps2_clk_i),
        .filt_o    (ps2_clk_f)
    );

    ps2_input_filter #(.DEB_CYCLES(DEB_CYCLES)) u_data_filt (
        .clk       (clk),
        .wb_rst_ni (wb_rst_ni),
        .raw_i     (ps2_data_i),
        .filt_o    (ps2_data_f)
    );

    assign fall = ps2_clk_prev_q & ~ps2_clk_f;

    // Frame decoder; the timeout watchdog restarts on every PS/2 clock fall.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        par_d     = par_q;
        tmo_d     = '0;
        frame_ok  = 1'b0;
        perr_set  = 1'b0;
        ferr_set  = 1'b0;
        if (!en_q) begin
            state_d = IDLE;
        end else begin
            if (state_q != IDLE && !fall) begin
                if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    ferr_set = 1'b1;
                    state_d  = IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            if (fall) begin
                case (state_q)
                    IDLE: begin
                        if (!ps2_data_f) begin
                            state_d   = DATA;
                            bit_cnt_d = '0;
                        end
                    end
                    DATA: begin
                        shift_d   = {ps2_data_f, shift_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) state_d = PARITY;
                    end
                    PARITY: begin
                        par_d   = ps2_data_f;
                        state_d = STOP;
                    end
                    default: begin
                        state_d  = IDLE;
                        perr_set = ~(^{shift_q, par_q});
                        ferr_set = ~ps2_data_f;
                        frame_ok = (^{shift_q, par_q}) & ps2_data_f;
                    end
                endcase
            end
        end
    end

`ifdef PS2_CODE_MERGE_EN
    logic pend_ext_q, pend_ext_d, pend_brk_q, pend_brk_d;

    always_comb begin
        pend_ext_d = pend_ext_q;
        pend_brk_d = pend_brk_q;
        push_req   = 1'b0;
        push_data  = {pend_brk_q, pend_ext_q, shift_q};
        if (perr_set || ferr_set) begin
            pend_ext_d = 1'b0;
            pend_brk_d = 1'b0;
        end else if (frame_ok) begin
            if (shift_q == CODE_EXT) begin
                pend_ext_d = 1'b1;
            end else if (shift_q == CODE_BRK) begin
                pend_brk_d = 1'b1;
            end else begin
                push_req   = 1'b1;
                pend_ext_d = 1'b0;
                pend_brk_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            pend_ext_q <= 1'b0;
            pend_brk_q <= 1'b0;
        end else begin
            pend_ext_q <= pend_ext_d;
            pend_brk_q <= pend_brk_d;
        end
    end
`else
    assign push_req  = frame_ok;
    assign push_data = shift_q;
`endif

    // Bus decode: an access is taken in the cycle before its ack.
    assign wb_req    = wb_cyc_i & wb_stb_i & ~wb_ack_q;
    assign wb_rd     = wb_req & ~wb_we_i;
    assign wb_wr     = wb_req & wb_we_i;
    assign reg_sel   = wb_adr_i[3:2];
    assign status_wr = wb_wr & (reg_sel == REG_STATUS);

    assign fifo_full   = (count_q == CW'(FIFO_DEPTH));
    assign fifo_nempty = (count_q != '0);
    assign do_pop      = wb_rd & (reg_sel == REG_DATA) & fifo_nempty;
    assign do_push     = push_req & (~fifo_full | do_pop);
    assign ovf_set     = push_req & fifo_full & ~do_pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
    end

    // NOTE: the storage array has no reset; only pointers and count define its contents.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    always_comb begin
        rdata = '0;
        case (reg_sel)
            REG_DATA: begin
                if (fifo_nempty) begin
                    rdata[ENTRY_W-1:0] = mem_q[rd_ptr_q];
                    rdata[VALID_BIT]   = 1'b1;
                end
            end
            REG_STATUS: begin
                rdata[ST_NEMPTY] = fifo_nempty;
                rdata[ST_FULL]   = fifo_full;
                rdata[ST_OVF]    = ovf_q;
                rdata[ST_PERR]   = perr_q;
                rdata[ST_FERR]   = ferr_q;
                rdata[15:8]      = 8'(count_q);
            end
            REG_CTRL: begin
                rdata[CTRL_EN]     = en_q;
                rdata[CTRL_IRQ_EN] = irq_en_q;
            end
            default: rdata = '0;
        endcase
    end

    // Sticky flags: a set event in the same cycle as a write-one-to-clear wins.
    always_comb begin
        ovf_d    = (ovf_q  & ~(status_wr & wb_dat_i[ST_OVF]))  | ovf_set;
        perr_d   = (perr_q & ~(status_wr & wb_dat_i[ST_PERR])) | perr_set;
        ferr_d   = (ferr_q & ~(status_wr & wb_dat_i[ST_FERR])) | ferr_set;
        en_d     = en_q;
        irq_en_d = irq_en_q;
        if (wb_wr && reg_sel == REG_CTRL) begin
            en_d     = wb_dat_i[CTRL_EN];
            irq_en_d = wb_dat_i[CTRL_IRQ_EN];
        end
        wb_ack_d = wb_cyc_i & wb_stb_i & ~wb_ack_q;
        wb_dat_d = wb_rd ? rdata : 32'h0;
        irq_d    = irq_en_q & (fifo_nempty | ovf_q | perr_q | ferr_q);
    end

    always_ff @(posedge clk or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            ps2_clk_prev_q <= 1'b1;
            state_q        <= IDLE;
            shift_q        <= '0;
            bit_cnt_q      <= '0;
            par_q          <= 1'b0;
            tmo_q          <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            ovf_q          <= 1'b0;
            perr_q         <= 1'b0;
            ferr_q         <= 1'b0;
            en_q           <= 1'b0;
            irq_en_q       <= 1'b0;
            wb_ack_q       <= 1'b0;
            wb_dat_q       <= '0;
            irq_q          <= 1'b0;
        end else begin
            ps2_clk_prev_q <= ps2_clk_f;
            state_q        <= state_d;
            shift_q        <= shift_d;
            bit_cnt_q      <= bit_cnt_d;
            par_q          <= par_d;
            tmo_q          <= tmo_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            ovf_q          <= ovf_d;
            perr_q         <= perr_d;
            ferr_q         <= ferr_d;
            en_q           <= en_d;
            irq_en_q       <= irq_en_d;
            wb_ack_q       <= wb_ack_d;
            wb_dat_q       <= wb_dat_d;
            irq_q          <= irq_d;
        end
    end

    assign wb_ack_o = wb_ack_q;
    assign wb_dat_o = wb_dat_q;
    assign wb_err_o = 1'b0;
    assign irq_o    = irq_q;

endmodule

// File: tb/tb_ps2_rx_fifo_wb.sv
// Self-checking bench for ps2_rx_fifo_wb with a scan-code scoreboard.
// Also covers the PS2_CODE_MERGE_EN build when that macro is defined.
`timescale 1ns/1ps
module tb_ps2_rx_fifo_wb;

    localparam int FIFO_DEPTH = 4;
    localparam int DEB        = 4;
    localparam int TMO        = 1500;
    localparam int HALF       = 12;

    localparam logic [31:0] A_DATA   = 32'h0;
    localparam logic [31:0] A_STATUS = 32'h4;
    localparam logic [31:0] A_CTRL   = 32'h8;
    localparam logic [31:0] A_RSVD   = 32'hC;

    logic        clk = 1'b0;
    logic        wb_rst_ni = 1'b1;
    logic        ps2_clk_i = 1'b1;
    logic        ps2_data_i = 1'b1;
    logic        wb_cyc_i = 1'b0;
    logic        wb_stb_i = 1'b0;
    logic        wb_we_i = 1'b0;
    logic [31:0] wb_adr_i = '0;
    logic [31:0] wb_dat_i = '0;
    logic [3:0]  wb_sel_i = 4'hF;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o, wb_err_o, irq_o;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] sb[$];

    always #5 clk = ~clk;

    ps2_rx_fifo_wb #(
        .FIFO_DEPTH     (FIFO_DEPTH),
        .DEB_CYCLES     (DEB),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk        (clk),
        .wb_rst_ni  (wb_rst_ni),
        .ps2_clk_i  (ps2_clk_i),
        .ps2_data_i (ps2_data_i),
        .wb_cyc_i   (wb_cyc_i),
        .wb_stb_i   (wb_stb_i),
        .wb_we_i    (wb_we_i),
        .wb_adr_i   (wb_adr_i),
        .wb_dat_i   (wb_dat_i),
        .wb_sel_i   (wb_sel_i),
        .wb_dat_o   (wb_dat_o),
        .wb_ack_o   (wb_ack_o),
        .wb_err_o   (wb_err_o),
        .irq_o      (irq_o)
    );

    function automatic logic [31:0] exp_data(input logic [7:0] b);
        logic [31:0] v;
        v = '0;
        v[7:0] = b;
`ifdef PS2_CODE_MERGE_EN
        v[16] = 1'b1;
`else
        v[8] = 1'b1;
`endif
        return v;
    endfunction

    function automatic logic [31:0] st(input int cnt, input bit ovf, input bit perr, input bit ferr);
        logic [31:0] v;
        v = '0;
        v[0] = (cnt > 0);
        v[1] = (cnt == FIFO_DEPTH);
        v[2] = ovf;
        v[3] = perr;
        v[4] = ferr;
        v[15:8] = 8'(cnt);
        return v;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wb_read(input logic [31:0] adr, output logic [31:0] dat, output bit ok);
        ok = 1'b0;
        dat = '0;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = adr;
        for (int i = 0; i < 4 && !ok; i++) begin
            tick(1);
            if (wb_ack_o === 1'b1) begin
                ok = 1'b1;
                dat = wb_dat_o;
            end
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        tick(1);
        if (!ok) begin
            n_tests++; n_fail++;
            $display("FAIL wb_read_ack adr=%h: ack never seen, expected within 4 cycles", adr);
        end
    endtask

    task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat);
        bit ok;
        ok = 1'b0;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = adr; wb_dat_i = dat;
        for (int i = 0; i < 4 && !ok; i++) begin
            tick(1);
            if (wb_ack_o === 1'b1) ok = 1'b1;
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        tick(1);
        if (!ok) begin
            n_tests++; n_fail++;
            $display("FAIL wb_write_ack adr=%h: ack never seen, expected within 4 cycles", adr);
        end
    endtask

    task automatic send_bit(input logic b);
        ps2_data_i = b;
        tick(HALF);
        ps2_clk_i = 1'b0;
        tick(HALF);
        ps2_clk_i = 1'b1;
    endtask

    // Start, eight data bits LSB first, parity; stop bit is left to the caller.
    task automatic send_head(input logic [7:0] b, input bit par_bad);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit((~^b) ^ par_bad);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit par_bad, input bit stop_bad);
        send_head(b, par_bad);
        send_bit(~stop_bad);
        ps2_data_i = 1'b1;
        tick(2 * HALF);
    endtask

    // Scoreboard consumer: reads DATA and compares with the oldest expected entry.
    task automatic sb_read_data(input string name);
        logic [31:0] d, e;
        bit ok;
        wb_read(A_DATA, d, ok);
        if (ok) begin
            e = (sb.size() == 0) ? 32'h0 : sb.pop_front();
            n_tests++;
            if (d !== e) begin
                n_fail++;
                $display("FAIL %s: DATA got %h expected %h", name, d, e);
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        bit ok;
        #3 wb_rst_ni = 1'b0;
        tick(3);
        n_tests++;
        if ({wb_ack_o, irq_o, wb_err_o, wb_dat_o} !== 35'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ack=%b irq=%b err=%b dat=%h expected all 0",
                     wb_ack_o, irq_o, wb_err_o, wb_dat_o);
        end
        wb_rst_ni = 1'b1;
        tick(DEB + 4);
        wb_read(A_STATUS, d, ok);
        n_tests++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL reset_status: got %h expected %h", d, 32'h0); end
        wb_read(A_CTRL, d, ok);
        n_tests++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL reset_ctrl: got %h expected %h", d, 32'h0); end
        send_frame(8'h1C, 1'b0, 1'b0);
        wb_read(A_STATUS, d, ok);
        n_tests++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL disabled_rx: STATUS got %h expected %h", d, 32'h0); end
    endtask

    task automatic test_basic();
        logic [31:0] d;
        bit ok;
        logic [7:0] pats [3] = '{8'h00, 8'hFF, 8'hA5};
        wb_write(A_CTRL, 32'h1);
        wb_read(A_CTRL, d, ok);
        n_tests++;
        if (d !== 32'h1) begin n_fail++; $display("FAIL ctrl_rw: got %h expected %h", d, 32'h1); end
        send_frame(8'h1C, 1'b0, 1'b0);
        sb.push_back(exp_data(8'h1C));
        wb_read(A_STATUS, d, ok);
        n_tests++;
        if (d !== 32'h0101) begin n_fail++; $display("FAIL basic_status: got %h expected %h", d, 32'h0101); end
        sb_read_data("basic_data");
        sb_read_data("empty_data");
        foreach (pats[i]) begin
            send_frame(pats[i], 1'b0, 1'b0);
            sb.push_back(exp_data(pats[i]));
        end
        wb_write(A_DATA, 32'hDEAD);
        wb_write(A_RSVD, 32'hFFFF);
        wb_read(A_RSVD, d, ok);
        n_tests++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL rsvd_read: got %h expected %h", d, 32'h0); end
        wb_read(A_STATUS, d, ok);
        n_tests++;
        if (d !== st(3, 0, 0, 0)) begin n_fail++; $display("FAIL three_status: got %h expected %h", d, st(3, 0, 0, 0)); end
        for (int i = 0; i < 3; i++) sb_read_data("pattern_data");
    endtask

    task automatic test_errors();
        logic [31:0] d;
        bit ok;
        send_frame(8'h1C, 1'b1, 1'b0);
        wb_read(A_STATUS, d, ok);
        n_tests++;
        if (d !== st(0, 0, 1, 0)) begin n_fail++; $display("FAIL perr_set: got %h expected %h", d, st(0, 0, 1, 0)); end
        wb_write(A_STATUS, 32'h8);
        wb_read(A_STATUS, d, ok);
        n_tests++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL perr_clear: got %h expected %h", d, 32'h0); end
        send_frame(8'h1C, 1'b0, 1'b1);
        wb_read(A_STATUS, d, ok);
        n_tests++;
        if (d !== st(0, 0, 0, 1)) begin n_fail++; $display("FAIL ferr_stop: got %h expected %h", d, st(0, 0, 0, 1)); end
        wb_write(A_STATUS, 32'h10);
    endtask

    task automatic test_timeout();
        logic [31:0] d;
        bit ok;
        logic [7:0] b;
        b = 8'h1C;
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(b[i]);
        ps2_data_i = 1'b1;
        tick(TMO + 100);
        wb_read(A_STATUS, d, ok);
        n_tests++;
        if (d !== st(0, 0, 0, 1)) begin n_fail++; $display("FAIL timeout_ferr: got %h expected %h", d, st(0, 0, 0, 1)); end
        wb_write(A_STATUS, 32'h10);
        send_frame(8'h29, 1'b0, 1'b0);
        sb.push_back(exp_data(8'h29));
        sb_read_data("after_timeout_data");
    endtask

    task automatic test_overflow();
        logic [31:0] d, e;
        bit ok;
        logic [7:0] bytes [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        foreach (bytes[i]) begin
            send_frame(bytes[i], 1'b0, 1'b0);
            if (i < FIFO_DEPTH) sb.push_back(exp_data(bytes[i]));
        end
        wb_read(A_STATUS, d, ok);
        n_tests++;
        if (d !== st(FIFO_DEPTH, 1, 0, 0)) begin n_fail++; $display("FAIL ovf_status: got %h expected %h", d, st(FIFO_DEPTH, 1, 0, 0)); end
        wb_write(A_STATUS, 32'h4);
        // Stop-bit fall of the next frame lands on the same edge as a DATA pop.
        send_head(8'h66, 1'b0);
        ps2_data_i = 1'b1;
        tick(HALF);
        ps2_clk_i = 1'b0;
        tick(DEB + 2);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = A_DATA;
        tick(1);
        d = wb_dat_o;
        ok = wb_ack_o;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        e = sb.pop_front();
        n_tests++;
        if (ok !== 1'b1 || d !== e) begin
            n_fail++;
            $display("FAIL collide_pop: ack=%b DATA got %h expected ack=1 DATA %h", ok, d, e);
        end
        sb.push_back(exp_data(8'h66));
        tick(HALF - DEB - 3);
        ps2_clk_i = 1'b1;
        tick(2 * HALF);
        wb_read(A_STATUS, d, ok);
        n_tests++;
        if (d !== st(FIFO_DEPTH, 0, 0, 0)) begin n_fail++; $display("FAIL collide_status: got %h expected %h", d, st(FIFO_DEPTH, 0, 0, 0)); end
        for (int i = 0; i < FIFO_DEPTH + 1; i++) sb_read_data("drain_data");
    endtask

    task automatic test_back_to_back();
        logic [3:0] acks;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = A_STATUS;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            acks[3-i] = wb_ack_o;
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        tick(1);
        n_tests++;
        if (acks !== 4'b1010) begin n_fail++; $display("FAIL back_to_back_ack: got %b expected %b", acks, 4'b1010); end
    endtask

    task automatic test_irq();
        wb_write(A_CTRL, 32'h3);
        tick(2);
        n_tests++;
        if (irq_o !== 1'b0) begin n_fail++; $display("FAIL irq_idle: got %b expected 0", irq_o); end
        send_head(8'h5A, 1'b0);
        ps2_data_i = 1'b1;
        tick(HALF);
        ps2_clk_i = 1'b0;
        tick(DEB + 5);
        sb.push_back(exp_data(8'h5A));
        n_tests++;
        if (irq_o !== 1'b1) begin n_fail++; $display("FAIL irq_on_push: got %b expected 1", irq_o); end
        tick(HALF - DEB - 5);
        ps2_clk_i = 1'b1;
        tick(2 * HALF);
        sb_read_data("irq_data");
        tick(2);
        n_tests++;
        if (irq_o !== 1'b0) begin n_fail++; $display("FAIL irq_drained: got %b expected 0", irq_o); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        bit ok;
        send_frame(8'h3C, 1'b0, 1'b0);
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = A_CTRL;
        tick(1);
        n_tests++;
        if ({wb_ack_o, irq_o, wb_dat_o} !== {1'b1, 1'b1, 32'h3}) begin
            n_fail++;
            $display("FAIL pre_reset: got ack=%b irq=%b dat=%h expected ack=1 irq=1 dat=3", wb_ack_o, irq_o, wb_dat_o);
        end
        #2 wb_rst_ni = 1'b0;
        #1;
        n_tests++;
        if ({wb_ack_o, irq_o, wb_err_o, wb_dat_o} !== 35'h0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: got ack=%b irq=%b err=%b dat=%h expected all 0",
                     wb_ack_o, irq_o, wb_err_o, wb_dat_o);
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        ps2_clk_i = 1'b1; ps2_data_i = 1'b1;
        sb.delete();
        tick(3);
        wb_rst_ni = 1'b1;
        tick(DEB + 4);
        wb_read(A_STATUS, d, ok);
        n_tests++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL post_reset_status: got %h expected %h", d, 32'h0); end
        wb_read(A_CTRL, d, ok);
        n_tests++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL post_reset_ctrl: got %h expected %h", d, 32'h0); end
    endtask

`ifdef PS2_CODE_MERGE_EN
    task automatic test_merge();
        logic [31:0] d;
        bit ok;
        wb_write(A_CTRL, 32'h1);
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h75, 1'b0, 1'b0);
        sb.push_back(32'h10375);
        wb_read(A_STATUS, d, ok);
        n_tests++;
        if (d !== st(1, 0, 0, 0)) begin n_fail++; $display("FAIL merge_status: got %h expected %h", d, st(1, 0, 0, 0)); end
        sb_read_data("merge_data");
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_errors();
        test_timeout();
        test_overflow();
        test_back_to_back();
        test_irq();
        test_reset_mid();
`ifdef PS2_CODE_MERGE_EN
        test_merge();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
